// File: rtl/an_decoder.sv
// an_decoder: single-error-correcting decoder for AN arithmetic codes, A = 47.
// A 23-bit received codeword is reduced mod 47. The residue identifies which
// bit (if any) flipped and in which direction. The codeword is corrected and
// then divided by 47 to give the 17-bit data word.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset, clears every register
//   in_valid      ane is sampled when high
//   ane[22:0]     received codeword
//   out_valid     nc and flags are valid this cycle
//   nc[16:0]      decoded data word (0 when uncorrectable)
//   corrected     a single-bit error was corrected
//   err_bit[4:0]  position of the corrected bit, 0 when none
//   uncorrectable corrected value is out of range
//
// Pipeline: ane is captured at edge k. R = ane mod 47 is registered at edge
// k+1. The lookup, correction, range check and divide are registered at edge
// k+2. The pipeline accepts one word per cycle and has no backpressure.
module an_decoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [22:0] ane,
  output logic        out_valid,
  output logic [16:0] nc,
  output logic        corrected,
  output logic [4:0]  err_bit,
  output logic        uncorrectable
);

  // Largest corrected value whose quotient still fits in 17 bits (47*131071).
  localparam logic [24:0] C_MAX = 25'd6160337;

  // floor(x/47) for x < 2^24: multiply by ceil(2^30/47), then keep the top bits.
  // The rounding error is 13/47 * 2^-30 per unit of x. That is small enough to
  // give exact results for every x below 2^26.
  function automatic logic [18:0] div47(input logic [23:0] x);
    logic [48:0] prod;
    prod = {25'd0, x} * {24'd0, 25'd22845571};
    return prod[48:30];
  endfunction

  // Syndrome ROM: residue -> {hit, add, bit}. "add" means the bit was lost
  // (1->0), so 2^bit is added back. Otherwise 2^bit is subtracted.
  function automatic logic [6:0] syn_lookup(input logic [5:0] r);
    logic [6:0] e;
    case (r)
      6'd1:    e = {2'b10, 5'd0};
      6'd2:    e = {2'b10, 5'd1};
      6'd3:    e = {2'b10, 5'd19};
      6'd4:    e = {2'b10, 5'd2};
      6'd5:    e = {2'b11, 5'd9};
      6'd6:    e = {2'b10, 5'd20};
      6'd7:    e = {2'b10, 5'd12};
      6'd8:    e = {2'b10, 5'd3};
      6'd9:    e = {2'b10, 5'd15};
      6'd10:   e = {2'b11, 5'd10};
      6'd11:   e = {2'b11, 5'd17};
      6'd12:   e = {2'b10, 5'd21};
      6'd13:   e = {2'b11, 5'd7};
      6'd14:   e = {2'b10, 5'd13};
      6'd15:   e = {2'b11, 5'd5};
      6'd16:   e = {2'b10, 5'd4};
      6'd17:   e = {2'b10, 5'd6};
      6'd18:   e = {2'b10, 5'd16};
      6'd19:   e = {2'b11, 5'd14};
      6'd20:   e = {2'b11, 5'd11};
      6'd21:   e = {2'b10, 5'd8};
      6'd22:   e = {2'b11, 5'd18};
      6'd23:   e = {2'b11, 5'd22};
      6'd24:   e = {2'b10, 5'd22};
      6'd25:   e = {2'b10, 5'd18};
      6'd26:   e = {2'b11, 5'd8};
      6'd27:   e = {2'b10, 5'd11};
      6'd28:   e = {2'b10, 5'd14};
      6'd29:   e = {2'b11, 5'd16};
      6'd30:   e = {2'b11, 5'd6};
      6'd31:   e = {2'b11, 5'd4};
      6'd32:   e = {2'b10, 5'd5};
      6'd33:   e = {2'b11, 5'd13};
      6'd34:   e = {2'b10, 5'd7};
      6'd35:   e = {2'b11, 5'd21};
      6'd36:   e = {2'b10, 5'd17};
      6'd37:   e = {2'b10, 5'd10};
      6'd38:   e = {2'b11, 5'd15};
      6'd39:   e = {2'b11, 5'd3};
      6'd40:   e = {2'b11, 5'd12};
      6'd41:   e = {2'b11, 5'd20};
      6'd42:   e = {2'b10, 5'd9};
      6'd43:   e = {2'b11, 5'd2};
      6'd44:   e = {2'b11, 5'd19};
      6'd45:   e = {2'b11, 5'd1};
      6'd46:   e = {2'b11, 5'd0};
      default: e = 7'd0;
    endcase
    return e;
  endfunction

  logic        v0_r, v1_r;
  logic [22:0] ane0_r, ane1_r;
  logic [5:0]  rem1_r;

  logic [18:0] q0_s;
  logic [23:0] rem0_s;
  logic [6:0]  entry_s;
  logic [24:0] pow_s;
  logic [24:0] c_s;
  logic        unc_s;
  logic [18:0] quot_s;
  logic [16:0] nc_s;

  logic        out_valid_r, corrected_r, uncorrectable_r;
  logic [16:0] nc_r;
  logic [4:0]  err_bit_r;

  // Residue of the captured codeword: ane - 47*floor(ane/47).
  always_comb begin
    q0_s   = div47({1'b0, ane0_r});
    rem0_s = {1'b0, ane0_r} - ({5'd0, q0_s} * 24'd47);
  end

  // Correction, range check and divide on the registered word and syndrome.
  // c_s uses 25 bits, so an underflow shows up as bit 24 set.
  always_comb begin
    entry_s = syn_lookup(rem1_r);
    pow_s   = 25'd1 << entry_s[4:0];
    c_s     = {2'b00, ane1_r};
    unc_s   = 1'b0;
    nc_s    = 17'd0;
    if (!entry_s[6]) begin
      c_s = {2'b00, ane1_r};
    end else if (entry_s[5]) begin
      c_s = {2'b00, ane1_r} + pow_s;
    end else begin
      c_s = {2'b00, ane1_r} - pow_s;
    end
    if (c_s[24]) begin
      unc_s = 1'b1;
    end else if (c_s > C_MAX) begin
      unc_s = 1'b1;
    end else begin
      unc_s = 1'b0;
    end
    quot_s = div47(c_s[23:0]);
    if (unc_s) begin
      nc_s = 17'd0;
    end else begin
      nc_s = quot_s[16:0];
    end
  end

  // Input capture and syndrome stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_r   <= 1'b0;
      ane0_r <= 23'd0;
      v1_r   <= 1'b0;
      ane1_r <= 23'd0;
      rem1_r <= 6'd0;
    end else begin
      v0_r   <= in_valid;
      ane0_r <= in_valid ? ane : ane0_r;
      v1_r   <= v0_r;
      ane1_r <= v0_r ? ane0_r : ane1_r;
      rem1_r <= v0_r ? rem0_s[5:0] : rem1_r;
    end
  end

  // Output registers. Data holds its last value across idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r     <= 1'b0;
      nc_r            <= 17'd0;
      corrected_r     <= 1'b0;
      err_bit_r       <= 5'd0;
      uncorrectable_r <= 1'b0;
    end else begin
      out_valid_r <= v1_r;
      if (v1_r) begin
        nc_r            <= nc_s;
        corrected_r     <= entry_s[6];
        err_bit_r       <= entry_s[4:0];
        uncorrectable_r <= unc_s;
      end
    end
  end

  assign out_valid     = out_valid_r;
  assign nc            = nc_r;
  assign corrected     = corrected_r;
  assign err_bit       = err_bit_r;
  assign uncorrectable = uncorrectable_r;

endmodule

// File: tb/tb_an_decoder.sv
// Self-checking bench for an_decoder. It uses directed vectors with hand-derived
// results, and a randomized stream checked against an arithmetic reference model.
module tb_an_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [22:0] ane;
  logic        out_valid;
  logic [16:0] nc;
  logic        corrected;
  logic [4:0]  err_bit;
  logic        uncorrectable;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [16:0] nc;
    logic        corr;
    logic [4:0]  eb;
    logic        unc;
  } exp_t;

  exp_t got;
  assign got = {nc, corrected, err_bit, uncorrectable};

  an_decoder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .ane(ane),
    .out_valid(out_valid), .nc(nc), .corrected(corrected),
    .err_bit(err_bit), .uncorrectable(uncorrectable)
  );

  always #5 clk = ~clk;

  // Reference: search every bit position for a power of two matching +/-R.
  function automatic exp_t model(input int unsigned a);
    exp_t        e;
    longint      c;
    int unsigned r, p;
    e = '0;
    c = longint'(a);
    r = a % 32'd47;
    if (r != 0) begin
      for (int i = 0; i < 23; i++) begin
        p = (32'd1 << i) % 32'd47;
        if (p == r) begin
          c = longint'(a) - (longint'(1) << i);
          e.corr = 1'b1; e.eb = i[4:0];
        end else if (32'd47 - p == r) begin
          c = longint'(a) + (longint'(1) << i);
          e.corr = 1'b1; e.eb = i[4:0];
        end
      end
    end
    if (c < 0 || c > longint'(8388607) || c / longint'(47) > longint'(131071))
      e.unc = 1'b1;
    else
      e.nc = 17'(c / longint'(47));
    return e;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; ane = 23'd57011;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({out_valid, got} !== 25'd0) begin
      n_err++;
      $display("FAIL reset_state: got ov=%0b nc=%0d corr=%0b eb=%0d unc=%0b, want all 0",
               out_valid, nc, corrected, err_bit, uncorrectable);
    end
    in_valid = 1'b0; rst_n = 1'b1;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL reset_release_idle[%0d]: out_valid=%0b want 0", t, out_valid);
      end
    end
  endtask

  task automatic test_directed();
    int unsigned d_ane [16] = '{57011, 57015, 57019, 57267, 4251315, 57010, 57009,
                                54963, 24243, 1, 46, 0, 8388607, 17, 6160337, 6160384};
    exp_t d_exp [16] = '{
      {17'd1213, 1'b0, 5'd0,  1'b0}, {17'd1213, 1'b1, 5'd2,  1'b0},
      {17'd1213, 1'b1, 5'd3,  1'b0}, {17'd1213, 1'b1, 5'd8,  1'b0},
      {17'd1213, 1'b1, 5'd22, 1'b0}, {17'd1213, 1'b1, 5'd0,  1'b0},
      {17'd1213, 1'b1, 5'd1,  1'b0}, {17'd1213, 1'b1, 5'd11, 1'b0},
      {17'd1213, 1'b1, 5'd15, 1'b0}, {17'd0,    1'b1, 5'd0,  1'b0},
      {17'd1,    1'b1, 5'd0,  1'b0}, {17'd0,    1'b0, 5'd0,  1'b0},
      {17'd0,    1'b0, 5'd0,  1'b1}, {17'd0,    1'b1, 5'd6,  1'b1},
      {17'd131071, 1'b0, 5'd0, 1'b0}, {17'd0,   1'b0, 5'd0,  1'b1}};
    for (int j = 0; j < 16; j++) begin
      @(negedge clk); in_valid = 1'b1; ane = 23'(d_ane[j]);
      @(negedge clk); in_valid = 1'b0; ane = 23'd0;
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL directed_early[%0d]: out_valid=%0b want 0 one edge early", j, out_valid);
      end
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b1 || got !== d_exp[j]) begin
        n_err++;
        $display("FAIL directed ane=%0d: got ov=%0b nc=%0d corr=%0b eb=%0d unc=%0b, want ov=1 nc=%0d corr=%0b eb=%0d unc=%0b",
                 d_ane[j], out_valid, nc, corrected, err_bit, uncorrectable,
                 d_exp[j].nc, d_exp[j].corr, d_exp[j].eb, d_exp[j].unc);
      end
    end
  endtask

  task automatic test_random();
    localparam int N = 400;
    logic        vin [N];
    int unsigned ain [N];
    exp_t        ein [N];
    exp_t        last;
    logic        have_last;
    int unsigned base;
    last = '0; have_last = 1'b0;
    for (int j = 0; j < N; j++) begin
      base = $urandom_range(131071, 0) * 32'd47;
      case ($urandom_range(2, 0))
        0:       ain[j] = base;
        1:       ain[j] = base ^ (32'd1 << $urandom_range(22, 0));
        default: ain[j] = $urandom & 32'h7F_FFFF;
      endcase
      vin[j] = (j == 0) || ($urandom_range(3, 0) != 0);
      ein[j] = model(ain[j]);
    end
    for (int t = 0; t < N + 3; t++) begin
      @(negedge clk);
      if (t >= 3) begin
        n_vec++;
        if (vin[t-3]) begin
          if (out_valid !== 1'b1 || got !== ein[t-3]) begin
            n_err++;
            $display("FAIL random ane=%0d: got ov=%0b nc=%0d corr=%0b eb=%0d unc=%0b, want ov=1 nc=%0d corr=%0b eb=%0d unc=%0b",
                     ain[t-3], out_valid, nc, corrected, err_bit, uncorrectable,
                     ein[t-3].nc, ein[t-3].corr, ein[t-3].eb, ein[t-3].unc);
          end
          last = ein[t-3]; have_last = 1'b1;
        end else if (out_valid !== 1'b0 || (have_last && got !== last)) begin
          n_err++;
          $display("FAIL random_idle_hold t=%0d: got ov=%0b nc=%0d corr=%0b eb=%0d unc=%0b, want ov=0 nc=%0d corr=%0b eb=%0d unc=%0b",
                   t, out_valid, nc, corrected, err_bit, uncorrectable,
                   last.nc, last.corr, last.eb, last.unc);
        end
      end
      if (t < N) begin
        in_valid = vin[t]; ane = 23'(ain[t]);
      end else begin
        in_valid = 1'b0; ane = 23'd0;
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 27; t++) begin
      @(negedge clk);
      if (t >= 3 && t < 26) begin
        n_vec++;
        if (out_valid !== 1'b1 || nc !== 17'd1213 || corrected !== 1'b1 ||
            err_bit !== 5'(t - 3) || uncorrectable !== 1'b0) begin
          n_err++;
          $display("FAIL back_to_back bit=%0d: got ov=%0b nc=%0d corr=%0b eb=%0d unc=%0b, want ov=1 nc=1213 corr=1 eb=%0d unc=0",
                   t - 3, out_valid, nc, corrected, err_bit, uncorrectable, t - 3);
        end
      end else if (t == 26) begin
        n_vec++;
        if (out_valid !== 1'b0) begin
          n_err++;
          $display("FAIL back_to_back_end: out_valid=%0b want 0", out_valid);
        end
      end
      if (t < 23) begin
        in_valid = 1'b1; ane = 23'(32'd57011 ^ (32'd1 << t));
      end else begin
        in_valid = 1'b0; ane = 23'd0;
      end
    end
  endtask

  task automatic test_reset_midstream();
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      in_valid = 1'b1; ane = 23'(32'd57011 ^ (32'd1 << (t + 2)));
    end
    n_vec++;
    if (out_valid !== 1'b1 || nc !== 17'd1213 || corrected !== 1'b1) begin
      n_err++;
      $display("FAIL midstream_pre_reset: got ov=%0b nc=%0d corr=%0b, want ov=1 nc=1213 corr=1",
               out_valid, nc, corrected);
    end
    #2 rst_n = 1'b0; in_valid = 1'b0;
    #1;
    n_vec++;
    if ({out_valid, got} !== 25'd0) begin
      n_err++;
      $display("FAIL midstream_reset_clear: got ov=%0b nc=%0d corr=%0b eb=%0d unc=%0b, want all 0",
               out_valid, nc, corrected, err_bit, uncorrectable);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL midstream_stale[%0d]: out_valid=%0b want 0", t, out_valid);
      end
    end
    in_valid = 1'b1; ane = 23'd57267;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL midstream_first_early: out_valid=%0b want 0", out_valid);
    end
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b1 || nc !== 17'd1213 || corrected !== 1'b1 ||
        err_bit !== 5'd8 || uncorrectable !== 1'b0) begin
      n_err++;
      $display("FAIL midstream_first: got ov=%0b nc=%0d corr=%0b eb=%0d unc=%0b, want ov=1 nc=1213 corr=1 eb=8 unc=0",
               out_valid, nc, corrected, err_bit, uncorrectable);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/an_decoder.md
# an_decoder

Pipelined single-error-correcting decoder for AN arithmetic codes with A = 47. It takes a 23-bit received codeword (ANe), corrects at most one flipped bit using the residue mod 47 as syndrome, and returns the 17-bit data word N = corrected/47. It sits downstream of AN-coded datapaths and storage, between the protected arithmetic and the plain-binary consumer.

## Interface
- No parameters; A = 47, codeword width 23, data width 17 are fixed.
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  ane is sampled when high.
- ane  in  23  received codeword, unsigned.
- out_valid  out  1  nc and flags are valid.
- nc  out  17  decoded data N.
- corrected  out  1  a single-bit error was found and corrected.
- err_bit  out  5  corrected bit position 0..22; 0 when corrected = 0.
- uncorrectable  out  1  the result is out of range; nc is forced to 0.

## Operation
- Syndrome: R = ane mod 47, range 0..46.
- R = 0: no error; C = ane.
- 2 has order 23 mod 47, so the 46 nonzero residues map one-to-one onto single-bit errors:
  - R = 2^i mod 47 for some i in 0..22: bit i flipped 0->1; C = ane − 2^i; corrected = 1; err_bit = i.
  - R = 47 − (2^i mod 47): bit i flipped 1->0; C = ane + 2^i; corrected = 1; err_bit = i.
- The syndrome table is a 47-entry constant ROM (R -> {sign, i}), implemented in combinational logic.
- Range check, with C held at 24 bits signed:
  - C < 0, C > 2^23−1, or C/47 > 131071 (C > 6160337) -> uncorrectable = 1, nc = 0.
  - In that case corrected and err_bit still report the syndrome decision.
- Otherwise nc = C/47, which is exact because C ≡ 0 mod 47. Division is by constant multiply or shift-add; no iterative divider.
- Multi-bit errors are outside the code's guarantee. The decoder still applies the table correction, which may alias to a wrong N; this is not flagged unless out of range.
- Idle cycles (in_valid = 0) produce out_valid = 0. Data outputs then hold their last values.

## Timing
- Two-stage pipeline, fully pipelined, one codeword accepted per cycle, no backpressure.
  - Stage 1: register ane, R and in_valid.
  - Stage 2: table lookup, correction, range check and divide; register the outputs.
- Latency: in_valid sampled at edge k -> out_valid and results at edge k+2.
- Reset (asynchronous, rst_n low) clears out_valid, nc, corrected, err_bit, uncorrectable and all pipeline registers to 0 immediately.
- Reset mid-stream discards in-flight words. The first valid output appears 2 edges after the first in_valid following reset release.
- Back-to-back inputs emerge back-to-back in order.

## Test plan
- Clean codeword: ane = 57011 (47·1213) -> nc = 1213, corrected = 0, uncorrectable = 0, 2 cycles later.
- Positive single errors: 57015 -> err_bit 2; 57019 -> bit 3; 57267 -> bit 8; 4251315 -> bit 22. Each gives nc = 1213, corrected = 1.
- Negative single errors: 57010 -> err_bit 0; 57009 -> bit 1; 54963 -> bit 11; 24243 -> bit 15. Each gives nc = 1213, corrected = 1.
- Small values: ane = 1 -> nc = 0, err_bit 0. ane = 46 -> nc = 1, err_bit 0. ane = 0 -> nc = 0, corrected = 0.
- Out of range: ane = 8388607 (47·178481, R = 0) -> uncorrectable = 1, nc = 0, corrected = 0.
- Pipeline and reset:
  - Stream all 23 single-error variants of 47·1213 back-to-back -> 23 consecutive out_valid cycles, each with nc = 1213 and the matching err_bit.
  - Assert rst_n low mid-stream -> all outputs go to 0 at once, and no stale out_valid appears after release.
